twiddle_stream_gen: RTL and testbench
=====================================

Name: twiddle_stream_gen

Overview:
Parametrised, sequential twiddle-factor generator for the SDF FFT/IFFT pipelines. It replaces per-stage hard-coded lookup tables with one block. The block tracks the sample position within a frame, derives the radix-2 DIF exponent for a runtime-selected stage, and reads a quarter-wave cosine ROM. It emits a registered complex twiddle for FFT (e^-jθ) or IFFT (e^+jθ) alongside each sample, one instance per multiplier stage.

Parameters:
NFFT, 64, FFT points; power of two, 8..4096.
LOG2N, $clog2(NFFT), index/counter width.
DATA_WIDTH, 15, signed twiddle width; must be >= FRAC_BITS+2.
FRAC_BITS, 10, fractional bits; unity = 2^FRAC_BITS.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous frame restart and pipeline flush
in_valid  in  1  sample accepted this cycle
mode_ifft  in  1  0 = FFT (conjugate twiddle), 1 = IFFT
stage  in  $clog2(LOG2N)  stage select 0..LOG2N-1
tw_real  out  DATA_WIDTH  signed real part
tw_imag  out  DATA_WIDTH  signed imaginary part
tw_valid  out  1  twiddle valid
tw_frame_start  out  1  twiddle belongs to frame index 0
tw_index  out  LOG2N  frame index n of this twiddle

Behaviour:
- Reset (rst_n low, asynchronous): cnt=0, latched mode/stage=0, pipeline valids=0, tw_real=tw_imag=0, tw_valid=0, tw_frame_start=0, tw_index=0.
- Frame counter cnt: increments on in_valid and wraps NFFT-1 -> 0. It holds when in_valid is low.
- Frame latching: mode_ifft and stage are sampled only when in_valid=1 and cnt=0, and are held for the whole frame. Changes mid-frame take effect at the next frame.
- Stage clamp: stage > LOG2N-1 is treated as LOG2N-1.
- Exponent for stage s, sample n=cnt:
  - L = NFFT>>s; p = n mod L.
  - e = 0 if p < L/2, else (p-L/2)<<s.
  - Range of e is 0..NFFT/2-1.
- ROM: NFFT/4+1 entries, ROM[i] = round-half-away(cos(2πi/NFFT)·2^FRAC_BITS), generated at elaboration. No external files.
- Quadrant mapping, Q = NFFT/4:
  - e <= Q: c = ROM[e], s = ROM[Q-e].
  - e > Q: c = -ROM[NFFT/2-e], s = ROM[e-Q].
- Output: tw_real = c; tw_imag = -s for FFT, +s for IFFT. Both are sign-extended to DATA_WIDTH. Negation never overflows, given the width rule.
- Pipeline, fixed latency 2 cycles from in_valid to tw_valid:
  - P1 registers cnt, e, quadrant flag, and the latched mode.
  - P2 registers the ROM reads and sign selection into the outputs.
- tw_index equals the n used. tw_frame_start = tw_valid & (tw_index==0).
- No backpressure: a bubble on in_valid produces a bubble on tw_valid 2 cycles later.
- When tw_valid=0, tw_real/tw_imag hold their last value.
- clear=1:
  - Next cycle cnt=0 and the P1/P2 valids=0.
  - tw_valid is low for the following 2 cycles.
  - An in_valid in the same cycle as clear is dropped (clear wins).
  - The latched mode and stage are kept until the next frame start.
- Reset mid-frame: everything returns to reset values immediately. The first accepted sample after release is n=0.
- Wrap: after n=NFFT-1 the next sample is n=0 with frame_start asserted and fresh mode/stage latched. There is no dead cycle.

Test Plan:
1. Reset, then NFFT=64, FRAC=10, stage 0, FFT, continuous in_valid:
   - n=0..31 -> (1024,0).
   - n=40 -> (724,-724).
   - n=48 -> (0,-1024).
   - n=56 -> (-724,-724).
   - tw_valid rises exactly 2 cycles after the first in_valid.
2. Same stimulus with mode_ifft=1 -> n=48 gives (0,1024); n=56 gives (-724,724).
3. Stage 2, FFT:
   - n=13 -> e=20 -> (-392,-946).
   - n=5 -> (1024,0).
   - Stage 5: every odd n -> (1024,0), since e=0 everywhere.
4. Toggle mode_ifft at n=20 of frame 0 -> frame 0 is unchanged; frame 1 (tw_frame_start pulse at tw_index=0) uses the new sign.
5. in_valid gaps (1-0-0-1 pattern) -> tw_valid mirrors the pattern 2 cycles later; tw_index stays contiguous.
6. Clear:
   - Assert clear with in_valid high at n=30 -> tw_valid low for 2 cycles, then the next sample is tw_index=0.
   - Async rst_n pulse mid-frame -> outputs are 0 immediately.

Source files
------------

// File: rtl/twiddle_stream_gen.sv
// twiddle_stream_gen: streaming radix-2 DIF twiddle-factor source for one SDF stage.
// Tracks the sample position within a frame, derives the exponent for the latched
// stage, and looks up a quarter-wave cosine ROM built at elaboration time. The
// complex twiddle (FFT: e^-j theta, IFFT: e^+j theta) appears two cycles after each
// accepted sample, together with its frame index.
module twiddle_stream_gen #(
    parameter int NFFT       = 64,
    parameter int LOG2N      = $clog2(NFFT),
    parameter int DATA_WIDTH = 15,
    parameter int FRAC_BITS  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic                         mode_ifft,
    input  logic [$clog2(LOG2N)-1:0]     stage,
    output logic signed [DATA_WIDTH-1:0] tw_real,
    output logic signed [DATA_WIDTH-1:0] tw_imag,
    output logic                         tw_valid,
    output logic                         tw_frame_start,
    output logic [LOG2N-1:0]             tw_index
);

    localparam int SW   = $clog2(LOG2N);
    localparam int EW   = LOG2N - 1;
    localparam int QTR  = NFFT / 4;
    localparam int HALF = NFFT / 2;
    localparam int MW   = FRAC_BITS + 1;
    localparam int PADW = DATA_WIDTH - MW;

    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [EW-1:0]    QTR_E      = EW'(QTR);
    localparam logic [LOG2N-1:0] HALF_N     = LOG2N'(HALF);
    localparam logic [LOG2N:0]   NFFT_W     = (LOG2N + 1)'(NFFT);
    localparam logic [LOG2N:0]   ONE_W      = (LOG2N + 1)'(1);

    // Rounded (half away from zero) cosine magnitude for ROM address idx.
    function automatic int romEntry(input int idx);
        real ang;
        real val;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(NFFT);
        val = $cos(ang) * (2.0 ** FRAC_BITS);
        if (val >= 0.0) begin
            return $rtoi(val + 0.5);
        end
        return -$rtoi(0.5 - val);
    endfunction

    // The table is padded to a power of two so every address value is in range;
    // entries above the quarter-wave point are never addressed.
    logic [MW-1:0] romTable [HALF];

    for (genvar i = 0; i < HALF; i++) begin : g_rom
        localparam int ENTRY = (i <= QTR) ? romEntry(i) : 0;
        assign romTable[i] = MW'(ENTRY);
    end

    logic [LOG2N-1:0]             cnt_q,      cnt_d;
    logic                         latMode_q,  latMode_d;
    logic [SW-1:0]                latStage_q, latStage_d;
    logic                         p1Valid_q,  p1Valid_d;
    logic [LOG2N-1:0]             p1Idx_q,    p1Idx_d;
    logic [EW-1:0]                p1Exp_q,    p1Exp_d;
    logic                         p1Quad_q,   p1Quad_d;
    logic                         p1Mode_q,   p1Mode_d;
    logic                         twValid_q,  twValid_d;
    logic [LOG2N-1:0]             twIdx_q,    twIdx_d;
    logic signed [DATA_WIDTH-1:0] twReal_q,   twReal_d;
    logic signed [DATA_WIDTH-1:0] twImag_q,   twImag_d;

    logic [SW-1:0]                stageClamp;
    logic [SW-1:0]                stageEff;
    logic                         modeEff;
    logic                         frameHead;
    logic [LOG2N:0]               lenW;
    logic [LOG2N:0]               halfW;
    logic [LOG2N:0]               posW;
    logic [EW-1:0]                expVal;
    logic                         quadVal;
    logic [EW-1:0]                addrC;
    logic [EW-1:0]                addrS;
    logic signed [DATA_WIDTH-1:0] cosExt;
    logic signed [DATA_WIDTH-1:0] sinExt;

    // Exponent for the current sample; sample 0 uses the incoming mode/stage directly.
    always_comb begin
        stageClamp = (stage > LAST_STAGE) ? LAST_STAGE : stage;
        frameHead  = (cnt_q == '0);
        stageEff   = frameHead ? stageClamp : latStage_q;
        modeEff    = frameHead ? mode_ifft : latMode_q;
        lenW       = NFFT_W >> stageEff;
        halfW      = lenW >> 1;
        posW       = {1'b0, cnt_q} & (lenW - ONE_W);
        expVal     = (posW >= halfW) ? EW'((posW - halfW) << stageEff) : '0;
        quadVal    = (expVal > QTR_E);
    end

    // Frame counter, per-frame latch and first pipeline stage; clear beats in_valid.
    always_comb begin
        cnt_d      = cnt_q;
        latMode_d  = latMode_q;
        latStage_d = latStage_q;
        p1Valid_d  = 1'b0;
        p1Idx_d    = p1Idx_q;
        p1Exp_d    = p1Exp_q;
        p1Quad_d   = p1Quad_q;
        p1Mode_d   = p1Mode_q;
        if (clear) begin
            cnt_d = '0;
        end else if (in_valid) begin
            cnt_d = cnt_q + LOG2N'(1);
            if (frameHead) begin
                latMode_d  = mode_ifft;
                latStage_d = stageClamp;
            end
            p1Valid_d = 1'b1;
            p1Idx_d   = cnt_q;
            p1Exp_d   = expVal;
            p1Quad_d  = quadVal;
            p1Mode_d  = modeEff;
        end
    end

    // Quadrant fold onto the ROM and sign selection for the output stage.
    always_comb begin
        addrC     = p1Quad_q ? EW'(HALF_N - {1'b0, p1Exp_q}) : p1Exp_q;
        addrS     = p1Quad_q ? (p1Exp_q - QTR_E) : (QTR_E - p1Exp_q);
        cosExt    = signed'({{PADW{1'b0}}, romTable[addrC]});
        sinExt    = signed'({{PADW{1'b0}}, romTable[addrS]});
        twValid_d = p1Valid_q & ~clear;
        twIdx_d   = twIdx_q;
        twReal_d  = twReal_q;
        twImag_d  = twImag_q;
        if (twValid_d) begin
            twIdx_d  = p1Idx_q;
            twReal_d = p1Quad_q ? -cosExt : cosExt;
            twImag_d = p1Mode_q ? sinExt : -sinExt;
        end
    end

    // State registers for counter, latch and both pipeline stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            latMode_q  <= 1'b0;
            latStage_q <= '0;
            p1Valid_q  <= 1'b0;
            p1Idx_q    <= '0;
            p1Exp_q    <= '0;
            p1Quad_q   <= 1'b0;
            p1Mode_q   <= 1'b0;
            twValid_q  <= 1'b0;
            twIdx_q    <= '0;
            twReal_q   <= '0;
            twImag_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            latMode_q  <= latMode_d;
            latStage_q <= latStage_d;
            p1Valid_q  <= p1Valid_d;
            p1Idx_q    <= p1Idx_d;
            p1Exp_q    <= p1Exp_d;
            p1Quad_q   <= p1Quad_d;
            p1Mode_q   <= p1Mode_d;
            twValid_q  <= twValid_d;
            twIdx_q    <= twIdx_d;
            twReal_q   <= twReal_d;
            twImag_q   <= twImag_d;
        end
    end

    assign tw_real        = twReal_q;
    assign tw_imag        = twImag_q;
    assign tw_valid       = twValid_q;
    assign tw_index       = twIdx_q;
    assign tw_frame_start = twValid_q & (twIdx_q == '0);

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Testbench for twiddle_stream_gen: known-value table, hand-written corner
// sequences and a randomized run checked against a trigonometric reference.
module tb_twiddle_stream_gen;

    localparam int NFFT       = 64;
    localparam int LOG2N      = $clog2(NFFT);
    localparam int DATA_WIDTH = 15;
    localparam int FRAC_BITS  = 10;
    localparam int SW         = $clog2(LOG2N);
    localparam real PI        = 3.14159265358979323846;

    logic                         clk;
    logic                         rst_n;
    logic                         clear;
    logic                         in_valid;
    logic                         mode_ifft;
    logic [SW-1:0]                stage;
    logic signed [DATA_WIDTH-1:0] tw_real;
    logic signed [DATA_WIDTH-1:0] tw_imag;
    logic                         tw_valid;
    logic                         tw_frame_start;
    logic [LOG2N-1:0]             tw_index;

    int compared   = 0;
    int mismatched = 0;

    twiddle_stream_gen #(
        .NFFT(NFFT), .LOG2N(LOG2N), .DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .mode_ifft(mode_ifft), .stage(stage), .tw_real(tw_real), .tw_imag(tw_imag),
        .tw_valid(tw_valid), .tw_frame_start(tw_frame_start), .tw_index(tw_index)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: frame position, per-frame latch, two-deep latency line.
    typedef struct {
        bit v;
        int idx;
        int re;
        int im;
    } tw_t;

    int  mCnt;
    bit  mMode;
    int  mStage;
    tw_t mP1;
    tw_t mOut;

    typedef struct {
        int stage;
        bit mode;
        int n;
        int expRe;
        int expIm;
    } vec_t;

    localparam int NTAB = 12;
    vec_t tab[NTAB];

    function automatic int rndHalfAway(input real x);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(0.5 - x));
    endfunction

    // Twiddle straight from the exponent rule and cos/sin of the angle.
    task automatic refTwiddle(input int n, input int s, input bit m, output int re, output int im);
        int  len;
        int  p;
        int  e;
        real th;
        int  sv;
        len = NFFT >> s;
        p   = n % len;
        e   = (p >= len / 2) ? (p - len / 2) * (1 << s) : 0;
        th  = 2.0 * PI * real'(e) / real'(NFFT);
        re  = rndHalfAway($cos(th) * (2.0 ** FRAC_BITS));
        sv  = rndHalfAway($sin(th) * (2.0 ** FRAC_BITS));
        im  = m ? sv : -sv;
    endtask

    task automatic modelReset();
        mCnt   = 0;
        mMode  = 1'b0;
        mStage = 0;
        mP1    = '{0, 0, 0, 0};
        mOut   = '{0, 0, 0, 0};
    endtask

    task automatic modelStep(input bit v, input bit m, input int s, input bit clr);
        tw_t nxt;
        nxt = '{0, 0, 0, 0};
        if (clr) begin
            mOut.v = 1'b0;
            mP1.v  = 1'b0;
            mCnt   = 0;
        end else begin
            if (v) begin
                if (mCnt == 0) begin
                    mMode  = m;
                    mStage = (s > LOG2N - 1) ? LOG2N - 1 : s;
                end
                nxt.v   = 1'b1;
                nxt.idx = mCnt;
                refTwiddle(mCnt, mStage, mMode, nxt.re, nxt.im);
                mCnt = (mCnt + 1) % NFFT;
            end
            mOut.v = mP1.v;
            if (mP1.v) mOut = mP1;
            mP1 = nxt;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkModel();
        checkOutput("valid", int'(tw_valid), int'(mOut.v));
        checkOutput("real", int'(tw_real), mOut.re);
        checkOutput("imag", int'(tw_imag), mOut.im);
        checkOutput("fstart", int'(tw_frame_start), int'(mOut.v && mOut.idx == 0));
        if (mOut.v) checkOutput("index", int'(tw_index), mOut.idx);
    endtask

    // One clock cycle: drive at the falling edge, step the model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit v, input bit m, input int s, input bit clr);
        in_valid  = v;
        mode_ifft = m;
        stage     = SW'(s);
        clear     = clr;
        @(posedge clk);
        modelStep(v, m, s, clr);
        @(negedge clk);
        checkModel();
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        #1;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tab[0]  = '{0, 1'b0, 0,  1024, 0};
        tab[1]  = '{0, 1'b0, 31, 1024, 0};
        tab[2]  = '{0, 1'b0, 40, 724, -724};
        tab[3]  = '{0, 1'b0, 48, 0, -1024};
        tab[4]  = '{0, 1'b0, 56, -724, -724};
        tab[5]  = '{0, 1'b1, 48, 0, 1024};
        tab[6]  = '{0, 1'b1, 56, -724, 724};
        tab[7]  = '{2, 1'b0, 13, -392, -946};
        tab[8]  = '{2, 1'b0, 5,  1024, 0};
        tab[9]  = '{5, 1'b0, 63, 1024, 0};
        tab[10] = '{7, 1'b0, 13, 1024, 0};
        tab[11] = '{0, 1'b0, 63, -1019, -100};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; mode_ifft = 1'b0; stage = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", int'(tw_valid), 0);
        checkOutput("rst_real", int'(tw_real), 0);
        checkOutput("rst_imag", int'(tw_imag), 0);
        checkOutput("rst_index", int'(tw_index), 0);
        checkOutput("rst_fstart", int'(tw_frame_start), 0);
        rst_n = 1'b1;

        // Latency: first sample appears two cycles after it is presented.
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkOutput("lat_cycle1", int'(tw_valid), 0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        checkOutput("lat_cycle2", int'(tw_valid), 1);

        // Known-value table.
        for (int t = 0; t < NTAB; t++) begin
            doReset();
            for (int n = 0; n <= tab[t].n; n++) applyStimulus(1'b1, tab[t].mode, tab[t].stage, 1'b0);
            applyStimulus(1'b0, 1'b0, 0, 1'b0);
            checkOutput($sformatf("tab%0d_valid", t), int'(tw_valid), 1);
            checkOutput($sformatf("tab%0d_index", t), int'(tw_index), tab[t].n);
            checkOutput($sformatf("tab%0d_re", t), int'(tw_real), tab[t].expRe);
            checkOutput($sformatf("tab%0d_im", t), int'(tw_imag), tab[t].expIm);
        end

        // Mode change mid-frame only affects the next frame.
        doReset();
        for (int k = 0; k < 2 * NFFT + 1; k++) begin
            applyStimulus(1'b1, (k >= 20), 0, 1'b0);
            if (k >= 1 && (k - 1) % NFFT == 48)
                checkOutput("toggle_im48", int'(tw_imag), ((k - 1) >= NFFT) ? 1024 : -1024);
            if (k - 1 == NFFT)
                checkOutput("toggle_fstart", int'(tw_frame_start), 1);
        end

        // Bubbles on in_valid reappear two cycles later.
        doReset();
        for (int k = 0; k < 25; k++) begin
            applyStimulus((k % 4 == 0) || (k % 4 == 3), 1'b0, 1, 1'b0);
            if (k >= 1)
                checkOutput("gap_valid", int'(tw_valid), int'(((k - 1) % 4 == 0) || ((k - 1) % 4 == 3)));
        end

        // Clear with in_valid high at n=30.
        doReset();
        for (int n = 0; n < 30; n++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("clr_valid1", int'(tw_valid), 0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkOutput("clr_valid2", int'(tw_valid), 0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkOutput("clr_valid3", int'(tw_valid), 1);
        checkOutput("clr_index", int'(tw_index), 0);

        // Asynchronous reset in the middle of a frame.
        for (int n = 0; n < 40; n++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", int'(tw_valid), 0);
        checkOutput("arst_real", int'(tw_real), 0);
        checkOutput("arst_imag", int'(tw_imag), 0);
        checkOutput("arst_index", int'(tw_index), 0);
        in_valid = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 3, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 1'b0);
        checkOutput("arst_first", int'(tw_index), 0);

        // Randomized traffic against the reference model.
        doReset();
        for (int k = 0; k < 2500; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)), $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
